// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI transmitter between P_NUM_REQ frame sources.
// Round-robin arbitration by default; defining SPI_ARB_FIXED_PRIO_EN switches
// to fixed priority (lowest index wins). The winning frame is latched and
// offered to the transmitter, its busy phase is tracked (with a timeout on
// the busy edge), and an idle gap is enforced before the next grant.
// The frame width defaults to 8 bits to match the system frame format.
module spi_tx_arbiter #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_WIDTH      = 8,
    parameter int P_GAP_CYCLES = 8,
    parameter int P_BUSY_TO    = 64
) (
    input  logic                           clk_100,
    input  logic                           s_rst,
    input  logic [P_NUM_REQ-1:0]           req_valid,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_data,
    output logic [P_NUM_REQ-1:0]           req_ready,
    input  logic                           tx_ready,
    output logic                           tx_valid,
    output logic [P_WIDTH-1:0]             tx_data,
    output logic [$clog2(P_NUM_REQ)-1:0]   grant_id,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           tx_timeout
);

    localparam int GW      = $clog2(P_NUM_REQ);
    localparam int CNT_MAX = (P_GAP_CYCLES > P_BUSY_TO) ? P_GAP_CYCLES : P_BUSY_TO;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(P_BUSY_TO - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((P_GAP_CYCLES > 0) ? (P_GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_OFFER     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [GW-1:0]        base_s;
    logic [GW-1:0]        winner_s;
    logic                 any_valid_s;
    logic                 accept_s;
    logic                 done_s;
    logic                 timeout_s;
    logic [P_WIDTH-1:0]   sel_frame_s;

    // Index base+offset wrapped into 0..P_NUM_REQ-1.
    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int offset);
        int sum_v;
        sum_v = int'(base) + offset;
        return (sum_v >= P_NUM_REQ) ? GW'(sum_v - P_NUM_REQ) : GW'(sum_v);
    endfunction

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign base_s = {GW{1'b0}};
`else
    logic [GW-1:0] last_r;

    assign base_s = wrap_idx(last_r, 1);

    // Round-robin pointer: remembers the most recent winner.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            last_r <= GW'(P_NUM_REQ - 1);
        end else if (accept_s) begin
            last_r <= winner_s;
        end
    end
`endif

    // Winner search: scan downwards so the entry closest to base_s wins last.
    always_comb begin
        winner_s    = {GW{1'b0}};
        any_valid_s = 1'b0;
        for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(base_s, k)]) begin
                winner_s    = wrap_idx(base_s, k);
                any_valid_s = 1'b1;
            end else begin
                winner_s    = winner_s;
                any_valid_s = any_valid_s;
            end
        end
    end

    assign accept_s    = (state_r == ST_IDLE) && any_valid_s;
    assign sel_frame_s = req_data[int'(winner_s)*P_WIDTH +: P_WIDTH];

    // Accept strobe is combinational so a transfer completes in the IDLE cycle.
    always_comb begin
        if (accept_s) begin
            req_ready = {{(P_NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            req_ready = {P_NUM_REQ{1'b0}};
        end
    end

    // Next-state logic plus the completion/timeout events.
    always_comb begin
        state_nxt_s = state_r;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = ST_OFFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (tx_ready) begin
                    state_nxt_s = ST_WAIT_BUSY;
                end else begin
                    state_nxt_s = ST_OFFER;
                end
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (cnt_r == BUSY_LAST) begin
                    timeout_s = 1'b1;
                    if (P_GAP_CYCLES == 0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    done_s = 1'b1;
                    if (P_GAP_CYCLES == 0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shared cycle counter: cleared on every state change, counts only in
    // the timed states, which exit at their terminal count so it never wraps.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_nxt_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_GAP)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_r    <= ST_IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= {P_WIDTH{1'b0}};
            grant_id   <= {GW{1'b0}};
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tx_valid   <= (state_nxt_s == ST_OFFER);
            busy       <= (state_nxt_s != ST_IDLE);
            frame_done <= done_s;
            tx_timeout <= timeout_s;
            if (accept_s) begin
                tx_data  <= sel_frame_s;
                grant_id <= winner_s;
            end
        end
    end

endmodule
